ce_gen_multi: RTL and testbench
===============================

Name: ce_gen_multi

Overview:
- Parametrised multi-channel clock-enable generator; replaces hand-written per-core divider counters (CPU, video, sound enables) in arcade emu tops.
- Each channel produces single-cycle enables at a rational rate NUM/DEN of clk_sys, using a phase accumulator; integer divide is the NUM=1 case.
- Runtime reprogramming, global phase sync and optional pause; sits beside the PLL, feeding core clk/clk_vid enable inputs and CE_PIXEL.

Parameters:
- CHANNELS, 2, number of independent enable channels (1..8)
- ACC_W, 16, width of NUM, DEN and accumulator per channel
- DEF_NUM, {CHANNELS{16'd1}}, packed reset-value numerators, channel 0 in LSBs
- DEF_DEN, {16'd19,16'd20}, packed reset-value denominators, channel 0 in LSBs

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_wr  in  1  single-cycle write strobe for one channel's rate
- cfg_ch  in  $clog2(CHANNELS) (min 1)  channel to write
- cfg_num  in  ACC_W  new numerator
- cfg_den  in  ACC_W  new denominator
- sync  in  1  zero all accumulators (phase alignment)
- pause  in  1  freeze all channels (only with CE_GEN_PAUSE_EN; port always present)
- ce  out  CHANNELS  registered enable pulses
- cfg_pending  out  CHANNELS  shadow rate written, not yet applied

Behaviour:
- Reset: acc=0, active num/den = DEF_NUM/DEF_DEN, shadow regs = defaults, ce=0, cfg_pending=0.
- Per channel, each clk_sys edge: sum = acc + num (ACC_W+1 bits, no overflow). sum >= den: acc <= sum - den, ce <= 1; else acc <= sum, ce <= 0.
- Latency: with num=1, den=D, first ce high after the D-th rising edge following reset release; thereafter period exactly D cycles. num/den=N/D yields exactly N pulses per D cycles, never two pulses closer than floor(D/N).
- Channel disabled (ce held 0, acc held) when num==0 or den==0.
- num > den: clamped, ce=1 every cycle, acc held 0.
- cfg_wr: loads shadow regs of cfg_ch, sets cfg_pending[cfg_ch]. Shadow applied (active num/den <= shadow, acc <= 0, pending cleared) on the cycle the channel asserts ce, or next cycle if channel currently disabled. No glitch: never a shortened period from mixed old/new values. cfg_wr on a pending channel overwrites shadow; last write wins.
- cfg_ch >= CHANNELS: write ignored.
- sync: all acc <= 0, ce <= 0 that cycle; pending shadows applied immediately. sync has priority over normal accumulation; cfg_wr in the same cycle lands in shadow and is applied by that sync.
- reset mid-period: ce drops immediately (async), accumulators and runtime configuration return to defaults.

Optional Feature:
- Macro CE_GEN_PAUSE_EN.
- Defined: pause=1 holds all acc, forces ce=0, defers application of pending shadows; on release, counting resumes from the held acc (no lost phase, next pulse at the remaining count). sync still acts while paused.
- Undefined: pause input ignored; logic removed.

Decomposition:
- Package ce_gen_pkg: ACC_W default constant, helper function for channel-index width (min 1), typedef for per-channel rate struct {num, den}.
- One sub-module ce_gen_chan: single accumulator + shadow/apply logic; top instantiates CHANNELS copies via generate and decodes cfg_ch.

Test Plan:
- Reset, ch0 num=1 den=20 -> first ce[0] on edge 20 after reset release, then every 20 cycles; ch1 1/19 -> period 19.
- ch0 cfg 3/7 -> exactly 3 pulses in every 7-cycle window over 700 cycles, pattern repeating every 7.
- ch0 running 1/20, cfg_wr 1/4 at cycle 5 of a period -> cfg_pending[0]=1 until next ce at cycle 20, then period 4, pending=0.
- Both channels at different phases, assert sync -> ce=0 that cycle; both next pulse exactly den cycles later, aligned.
- cfg num=5 den=3 -> ce every cycle; cfg num=0 -> ce stays 0, pending clears next cycle; cfg_ch out of range -> no change.
- CE_GEN_PAUSE_EN: 1/10, pause 30 cycles after 4 counts -> no ce during pause, next ce 6 cycles after release; reset asserted mid-pause -> ce=0, defaults restored.

Source files
------------

// File: rtl/ce_gen_pkg.sv
// Shared constants, types and helpers for the ce_gen_multi clock-enable generator.
package ce_gen_pkg;

  localparam int ACC_W_DEF = 16;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] num;
    logic [ACC_W_DEF-1:0] den;
  } rate_t;

  // A single-channel build still needs a 1-bit select port.
  function automatic int chIdxW(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/ce_gen_chan.sv
// One rational-rate enable channel: phase accumulator plus shadow rate registers.
// Optional pause support is compiled in with CE_GEN_PAUSE_EN.
module ce_gen_chan
  import ce_gen_pkg::*;
#(
  parameter int               ACC_W   = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEF_NUM = 1,
  parameter logic [ACC_W-1:0] DEF_DEN = 20
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_i,
  input  logic [ACC_W-1:0] wrNum_i,
  input  logic [ACC_W-1:0] wrDen_i,
  input  logic             sync_i,
  input  logic             pause_i,
  output logic             ce_o,
  output logic             pending_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] num_q, num_d;
  logic [ACC_W-1:0] den_q, den_d;
  logic [ACC_W-1:0] shNum_q, shNum_d;
  logic [ACC_W-1:0] shDen_q, shDen_d;
  logic             pending_q, pending_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  logic             disabled, clamp, apply, paused;

`ifdef CE_GEN_PAUSE_EN
  assign paused = pause_i;
`else
  logic unused_pause;
  assign paused       = 1'b0;
  assign unused_pause = pause_i;
`endif

  // New rates only take effect at a period boundary (or on sync), so no period is ever shortened.
  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, num_q};
    disabled  = (num_q == '0) || (den_q == '0);
    clamp     = num_q > den_q;
    acc_d     = acc_q;
    num_d     = num_q;
    den_d     = den_q;
    shNum_d   = wr_i ? wrNum_i : shNum_q;
    shDen_d   = wr_i ? wrDen_i : shDen_q;
    pending_d = pending_q | wr_i;
    ce_d      = 1'b0;
    apply     = 1'b0;
    if (sync_i) begin
      acc_d = '0;
      if (pending_q || wr_i) begin
        num_d     = shNum_d;
        den_d     = shDen_d;
        pending_d = 1'b0;
      end
    end else if (!paused) begin
      if (disabled) begin
        apply = pending_q;
      end else begin
        if (clamp) begin
          ce_d  = 1'b1;
          acc_d = '0;
        end else if (sum >= {1'b0, den_q}) begin
          ce_d  = 1'b1;
          acc_d = ACC_W'(sum - {1'b0, den_q});
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        apply = pending_q && ce_d;
      end
      if (apply) begin
        num_d     = shNum_q;
        den_d     = shDen_q;
        acc_d     = '0;
        pending_d = wr_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q     <= '0;
      num_q     <= DEF_NUM;
      den_q     <= DEF_DEN;
      shNum_q   <= DEF_NUM;
      shDen_q   <= DEF_DEN;
      pending_q <= 1'b0;
      ce_q      <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      num_q     <= num_d;
      den_q     <= den_d;
      shNum_q   <= shNum_d;
      shDen_q   <= shDen_d;
      pending_q <= pending_d;
      ce_q      <= ce_d;
    end
  end

  assign ce_o      = ce_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/ce_gen_multi.sv
// Multi-channel rational clock-enable generator: one ce_gen_chan per channel, shared config bus.
// Pause input is honoured only when built with CE_GEN_PAUSE_EN.
module ce_gen_multi
  import ce_gen_pkg::*;
#(
  parameter int                        CHANNELS = 2,
  parameter int                        ACC_W    = ACC_W_DEF,
  parameter logic [CHANNELS*ACC_W-1:0] DEF_NUM  = {CHANNELS{16'd1}},
  parameter logic [CHANNELS*ACC_W-1:0] DEF_DEN  = {16'd19, 16'd20}
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          cfg_wr,
  input  logic [chIdxW(CHANNELS)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]              cfg_num,
  input  logic [ACC_W-1:0]              cfg_den,
  input  logic                          sync,
  input  logic                          pause,
  output logic [CHANNELS-1:0]           ce,
  output logic [CHANNELS-1:0]           cfg_pending
);

  localparam int CHW = chIdxW(CHANNELS);

  // Out-of-range channel numbers match no instance, so such writes are dropped.
  for (genvar c = 0; c < CHANNELS; c++) begin : gChan
    logic wrSel;
    assign wrSel = cfg_wr && (cfg_ch == CHW'(c));

    ce_gen_chan #(
      .ACC_W   (ACC_W),
      .DEF_NUM (DEF_NUM[c*ACC_W +: ACC_W]),
      .DEF_DEN (DEF_DEN[c*ACC_W +: ACC_W])
    ) uChan (
      .clk_i     (clk_sys),
      .reset_i   (reset),
      .wr_i      (wrSel),
      .wrNum_i   (cfg_num),
      .wrDen_i   (cfg_den),
      .sync_i    (sync),
      .pause_i   (pause),
      .ce_o      (ce[c]),
      .pending_o (cfg_pending[c])
    );
  end

endmodule

// File: tb/tb_ce_gen_multi.sv
// Directed self-checking bench for ce_gen_multi (3 channels so an out-of-range cfg_ch exists).
// Pause scenarios run only when built with CE_GEN_PAUSE_EN.
module tb_ce_gen_multi;

  localparam int NCH = 3;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            cfg_wr;
  logic [1:0]      cfg_ch;
  logic [15:0]     cfg_num;
  logic [15:0]     cfg_den;
  logic            sync;
  logic            pause;
  logic [NCH-1:0]  ce;
  logic [NCH-1:0]  cfg_pending;

  int total = 0;
  int bad   = 0;
  int firstHit  [NCH];
  int secondHit [NCH];
  int hitCnt    [NCH];

  ce_gen_multi #(
    .CHANNELS (NCH),
    .ACC_W    (16),
    .DEF_NUM  ({3{16'd1}}),
    .DEF_DEN  ({16'd9, 16'd19, 16'd20})
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_num     (cfg_num),
    .cfg_den     (cfg_den),
    .sync        (sync),
    .pause       (pause),
    .ce          (ce),
    .cfg_pending (cfg_pending)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input bit wr, input int ch, input int num, input int den, input bit syncV);
    cfg_wr  = wr;
    cfg_ch  = 2'(ch);
    cfg_num = 16'(num);
    cfg_den = 16'(den);
    sync    = syncV;
    tick();
    cfg_wr  = 1'b0;
    sync    = 1'b0;
  endtask

  task automatic runWindow(input int n);
    for (int c = 0; c < NCH; c++) begin
      firstHit[c]  = 0;
      secondHit[c] = 0;
      hitCnt[c]    = 0;
    end
    for (int i = 1; i <= n; i++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (ce[c]) begin
          hitCnt[c]++;
          if (firstHit[c] == 0) firstHit[c] = i;
          else if (secondHit[c] == 0) secondHit[c] = i;
        end
      end
    end
  endtask

  task automatic waitCe(input int ch, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ce[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int patErr;
    int pulses;
    int lastHit;
    int minGap;
    bit expCe;

    reset = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0;
    sync = 1'b0; pause = 1'b0;
    tick(); tick(); tick();
    checkOutput("reset_ce", int'(ce), 0);
    checkOutput("reset_pending", int'(cfg_pending), 0);
    reset = 1'b0;

    // default rates 1/20, 1/19, 1/9 from reset release
    runWindow(40);
    checkOutput("ch0_first", firstHit[0], 20);
    checkOutput("ch0_second", secondHit[0], 40);
    checkOutput("ch1_first", firstHit[1], 19);
    checkOutput("ch1_second", secondHit[1], 38);
    checkOutput("ch2_first", firstHit[2], 9);
    checkOutput("ch2_count", hitCnt[2], 4);

    // rate change mid-period waits for the current period to end
    runWindow(4);
    checkOutput("ch0_quiet", hitCnt[0], 0);
    applyStimulus(1'b1, 0, 1, 4, 1'b0);
    checkOutput("pend_set", int'(cfg_pending), 1);
    checkOutput("pend_set_ce", int'(ce[0]), 0);
    runWindow(14);
    checkOutput("pend_hold_cnt", hitCnt[0], 0);
    checkOutput("pend_hold", int'(cfg_pending[0]), 1);
    tick();
    checkOutput("apply_ce", int'(ce[0]), 1);
    checkOutput("apply_pend", int'(cfg_pending[0]), 0);
    runWindow(8);
    checkOutput("new_first", firstHit[0], 4);
    checkOutput("new_second", secondHit[0], 8);

    // sync lands where ch0 and ch2 would both pulse
    runWindow(3);
    checkOutput("pre_sync_quiet", hitCnt[0], 0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1);
    checkOutput("sync_ce", int'(ce), 0);
    runWindow(19);
    checkOutput("sync_ch0_first", firstHit[0], 4);
    checkOutput("sync_ch0_second", secondHit[0], 8);
    checkOutput("sync_ch1_first", firstHit[1], 19);
    checkOutput("sync_ch2_first", firstHit[2], 9);
    checkOutput("sync_ch2_second", secondHit[2], 18);

    // sync with a same-cycle write applies 3/7 at once: pattern 0010101
    applyStimulus(1'b1, 0, 3, 7, 1'b1);
    checkOutput("sync_wr_pend", int'(cfg_pending), 0);
    checkOutput("sync_wr_ce", int'(ce[0]), 0);
    patErr = 0; pulses = 0; lastHit = 0; minGap = 1000;
    for (int i = 1; i <= 700; i++) begin
      tick();
      expCe = (i % 7 == 0) || (i % 7 == 3) || (i % 7 == 5);
      if (ce[0] != expCe) patErr++;
      if (ce[0]) begin
        pulses++;
        if (lastHit != 0 && (i - lastHit) < minGap) minGap = i - lastHit;
        lastHit = i;
      end
    end
    checkOutput("r37_pattern_err", patErr, 0);
    checkOutput("r37_pulses", pulses, 300);
    checkOutput("r37_min_gap", minGap, 2);

    // num > den clamps to every cycle
    applyStimulus(1'b1, 0, 5, 3, 1'b0);
    checkOutput("clamp_pend", int'(cfg_pending), 1);
    waitCe(0, 20, n);
    checkOutput("clamp_apply_wait", n, 2);
    checkOutput("clamp_apply_pend", int'(cfg_pending[0]), 0);
    runWindow(10);
    checkOutput("clamp_cnt", hitCnt[0], 10);

    // num = 0 disables the channel
    applyStimulus(1'b1, 0, 0, 3, 1'b0);
    checkOutput("dis_pend", int'(cfg_pending[0]), 1);
    checkOutput("dis_last_ce", int'(ce[0]), 1);
    tick();
    checkOutput("dis_pend_clr", int'(cfg_pending[0]), 0);
    runWindow(30);
    checkOutput("dis_cnt", hitCnt[0], 0);

    // a disabled channel picks up a new rate on the next cycle
    applyStimulus(1'b1, 0, 1, 5, 1'b0);
    checkOutput("reen_pend", int'(cfg_pending[0]), 1);
    tick();
    checkOutput("reen_pend_clr", int'(cfg_pending[0]), 0);
    checkOutput("reen_ce", int'(ce[0]), 0);
    runWindow(10);
    checkOutput("reen_first", firstHit[0], 5);
    checkOutput("reen_second", secondHit[0], 10);

    // out-of-range channel write is dropped
    applyStimulus(1'b1, 3, 2, 2, 1'b0);
    checkOutput("oor_pend", int'(cfg_pending), 0);
    runWindow(9);
    checkOutput("oor_first", firstHit[0], 4);
    checkOutput("oor_second", secondHit[0], 9);
    checkOutput("oor_ce_high", int'(ce[0]), 1);

    // async reset drops ce immediately and restores defaults
    reset = 1'b1;
    #2;
    checkOutput("async_rst_ce", int'(ce), 0);
    checkOutput("async_rst_pend", int'(cfg_pending), 0);
    tick();
    reset = 1'b0;
    runWindow(20);
    checkOutput("rst_def_ch0", firstHit[0], 20);
    checkOutput("rst_def_ch1", firstHit[1], 19);
    checkOutput("rst_def_ch2", firstHit[2], 9);

`ifdef CE_GEN_PAUSE_EN
    applyStimulus(1'b1, 0, 1, 10, 1'b1);
    runWindow(4);
    checkOutput("pause_pre_cnt", hitCnt[0], 0);
    pause = 1'b1;
    runWindow(30);
    checkOutput("pause_ch0_cnt", hitCnt[0], 0);
    checkOutput("pause_ch1_cnt", hitCnt[1], 0);
    checkOutput("pause_ch2_cnt", hitCnt[2], 0);
    pause = 1'b0;
    waitCe(0, 20, n);
    checkOutput("pause_resume", n, 6);
    pause = 1'b1;
    runWindow(3);
    applyStimulus(1'b1, 1, 1, 3, 1'b0);
    runWindow(2);
    checkOutput("pause_defer_pend", int'(cfg_pending), 2);
    reset = 1'b1;
    #2;
    checkOutput("pause_rst_ce", int'(ce), 0);
    checkOutput("pause_rst_pend", int'(cfg_pending), 0);
    tick();
    pause = 1'b0;
    reset = 1'b0;
    runWindow(20);
    checkOutput("pause_rst_ch0", firstHit[0], 20);
    checkOutput("pause_rst_ch1", firstHit[1], 19);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
